// File: rtl/mdu_seq_ctrl_pkg.sv
// Shared op codes, FSM state codes and small helpers for the MDU sequencer.
// Any module that needs these names imports this package.
package mdu_seq_ctrl_pkg;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_MF    = 3'd7
    } mdu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } mdu_state_e;

    function automatic logic op_is_signed(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/mdu_seq_ctrl_if.sv
// Bundle of signals between the ID/EXE pipeline (master) and the MDU (slave).
// The pipeline drives op/operands; the MDU returns HI/LO, busy and stall.
interface mdu_seq_ctrl_if #(parameter int WIDTH = 32);

    // Handshake: i_MDU_valid qualifies i_MDU_op/rs/rt for the current cycle. A valid
    // non-NOP op is taken at the next posedge unless o_MDU_stall is high in that cycle
    // (stall is the inverse of ready); a stalled op must be held and re-presented.
    logic             i_MDU_valid;
    logic [2:0]       i_MDU_op;
    logic [WIDTH-1:0] i_MDU_rs;
    logic [WIDTH-1:0] i_MDU_rt;
    logic [WIDTH-1:0] o_MDU_hi;
    logic [WIDTH-1:0] o_MDU_lo;
    logic             o_MDU_busy;
    logic             o_MDU_stall;

    modport master (
        output i_MDU_valid, i_MDU_op, i_MDU_rs, i_MDU_rt,
        input  o_MDU_hi, o_MDU_lo, o_MDU_busy, o_MDU_stall
    );

    modport slave (
        input  i_MDU_valid, i_MDU_op, i_MDU_rs, i_MDU_rt,
        output o_MDU_hi, o_MDU_lo, o_MDU_busy, o_MDU_stall
    );

endinterface

// File: rtl/mdu_seq_ctrl_iter.sv
// Iteration datapath: one shift-add multiply step or one restoring divide step per cycle.
// Operates on magnitudes; the final sign fix is applied combinationally on the outputs.
module mdu_seq_ctrl_iter #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_load,
    input  logic             i_step_mul,
    input  logic             i_step_div,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_is_div,
    input  logic             i_neg_main,
    input  logic             i_neg_rem,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    // Multiply: low half holds the multiplier, upper half the partial product.
    // Divide: low half holds the dividend/quotient, upper half the remainder.
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opnd;

    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_div_shift;
    logic               w_div_ge;
    logic [WIDTH-1:0]   w_div_sub;
    logic [2*WIDTH-1:0] w_prod;

    assign w_mul_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    assign w_div_shift = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_div_ge    = (w_div_shift >= {1'b0, r_opnd});
    // Remainder always stays below the divisor, so the low WIDTH bits of the difference suffice.
    assign w_div_sub   = w_div_shift[WIDTH-1:0] - r_opnd;

    always_ff @(posedge i_clk) begin
        if (i_load) begin
            r_acc  <= {{WIDTH{1'b0}}, i_a};
            r_opnd <= i_b;
        end else if (i_step_mul) begin
            r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
        end else if (i_step_div) begin
            r_acc <= {(w_div_ge ? w_div_sub : w_div_shift[WIDTH-1:0]),
                      r_acc[WIDTH-2:0], w_div_ge};
        end
    end

    always_comb begin
        w_prod = i_neg_main ? -r_acc : r_acc;
        o_hi   = w_prod[2*WIDTH-1:WIDTH];
        o_lo   = w_prod[WIDTH-1:0];
        if (i_is_div) begin
            o_lo = i_neg_main ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
            o_hi = i_neg_rem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
        end
    end

endmodule

// File: rtl/mdu_seq_ctrl.sv
// Multiply/divide sequencer and HI/LO owner beside the EXE stage ALU.
// Holds the FSM, iteration counter, sign flags, HI/LO and the pipeline stall.
module mdu_seq_ctrl
    import mdu_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic         i_MDU_clk,
    input  logic         i_MDU_rst,
    mdu_seq_ctrl_if.slave bus,
    output mdu_state_e   o_MDU_dbg_state
);

    mdu_state_e       r_state;
    mdu_state_e       w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_is_div;
    logic             r_neg_main;
    logic             r_neg_rem;
    logic             r_div0;
    logic [WIDTH-1:0] r_rs_raw;

    logic             w_accept;
    logic             w_start_mul;
    logic             w_start_div;
    logic             w_rs_neg;
    logic             w_rt_neg;
    logic [WIDTH-1:0] w_rs_mag;
    logic [WIDTH-1:0] w_rt_mag;
    logic             w_step_mul;
    logic             w_step_div;
    logic             w_write;
    logic             w_last;
    logic [WIDTH-1:0] w_core_hi;
    logic [WIDTH-1:0] w_core_lo;

    assign w_accept    = bus.i_MDU_valid && (bus.i_MDU_op != OP_NOP) && (r_state == S_IDLE);
    assign w_start_mul = w_accept && ((bus.i_MDU_op == OP_MULT) || (bus.i_MDU_op == OP_MULTU));
    assign w_start_div = w_accept && ((bus.i_MDU_op == OP_DIV) || (bus.i_MDU_op == OP_DIVU));
    assign w_rs_neg    = op_is_signed(bus.i_MDU_op) && bus.i_MDU_rs[WIDTH-1];
    assign w_rt_neg    = op_is_signed(bus.i_MDU_op) && bus.i_MDU_rt[WIDTH-1];
    // Negating the most-negative value yields itself, which read unsigned is the right magnitude.
    assign w_rs_mag    = w_rs_neg ? -bus.i_MDU_rs : bus.i_MDU_rs;
    assign w_rt_mag    = w_rt_neg ? -bus.i_MDU_rt : bus.i_MDU_rt;
    assign w_last      = (r_cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge i_MDU_clk) begin
        if (i_MDU_rst) r_state <= S_IDLE;
        else           r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_step_mul   = 1'b0;
        w_step_div   = 1'b0;
        w_write      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start_mul)      w_next_state = S_MUL;
                else if (w_start_div) w_next_state = S_DIV;
            end
            S_MUL: begin
                w_step_mul = 1'b1;
                if (w_last) w_next_state = S_FIX;
            end
            S_DIV: begin
                w_step_div = 1'b1;
                if (w_last) w_next_state = S_FIX;
            end
            S_FIX: begin
                w_write      = 1'b1;
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge i_MDU_clk) begin
        if (w_start_mul || w_start_div) begin
            r_is_div   <= w_start_div;
            r_neg_main <= w_rs_neg ^ w_rt_neg;
            r_neg_rem  <= w_rs_neg;
            r_div0     <= (bus.i_MDU_rt == '0);
            r_rs_raw   <= bus.i_MDU_rs;
        end
    end

    always_ff @(posedge i_MDU_clk) begin
        if (i_MDU_rst) begin
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_hi   <= '0;
            r_lo   <= '0;
        end else begin
            if (w_start_mul || w_start_div) begin
                r_cnt  <= '0;
                r_busy <= 1'b1;
            end else if (w_step_mul || w_step_div) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_write) begin
                r_busy <= 1'b0;
                if (r_is_div && r_div0) begin
                    r_hi <= r_rs_raw;
                    r_lo <= '1;
                end else begin
                    r_hi <= w_core_hi;
                    r_lo <= w_core_lo;
                end
            end else if (w_accept && (bus.i_MDU_op == OP_MTHI)) begin
                r_hi <= bus.i_MDU_rs;
            end else if (w_accept && (bus.i_MDU_op == OP_MTLO)) begin
                r_lo <= bus.i_MDU_rs;
            end
        end
    end

    mdu_seq_ctrl_iter #(.WIDTH(WIDTH)) u_iter (
        .i_clk      (i_MDU_clk),
        .i_load     (w_start_mul || w_start_div),
        .i_step_mul (w_step_mul),
        .i_step_div (w_step_div),
        .i_a        (w_start_mul ? w_rt_mag : w_rs_mag),
        .i_b        (w_start_mul ? w_rs_mag : w_rt_mag),
        .i_is_div   (r_is_div),
        .i_neg_main (r_neg_main),
        .i_neg_rem  (r_neg_rem),
        .o_hi       (w_core_hi),
        .o_lo       (w_core_lo)
    );

    assign bus.o_MDU_hi     = r_hi;
    assign bus.o_MDU_lo     = r_lo;
    assign bus.o_MDU_busy   = r_busy;
    assign bus.o_MDU_stall  = r_busy && bus.i_MDU_valid && (bus.i_MDU_op != OP_NOP);
    assign o_MDU_dbg_state  = r_state;

endmodule

// File: tb/tb_mdu_seq_ctrl.sv
// Self-checking bench for mdu_seq_ctrl: directed vector table, random ops against a
// plain-arithmetic reference model, and hand sequences for stall and mid-sequence reset.
module tb_mdu_seq_ctrl;
    import mdu_seq_ctrl_pkg::*;

    localparam int W    = 32;
    localparam int LAT  = W + 1;
    localparam int NVEC = 13;

    logic       clk;
    logic       rst;
    mdu_state_e dbg_state;
    int         n_checks;
    int         n_pass;

    mdu_seq_ctrl_if #(.WIDTH(W)) bus ();

    mdu_seq_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
        .i_MDU_clk       (clk),
        .i_MDU_rst       (rst),
        .bus             (bus),
        .o_MDU_dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] rs;
        logic [W-1:0] rt;
        logic [W-1:0] exp_hi;
        logic [W-1:0] exp_lo;
        int           exp_cyc;
    } vec_t;

    vec_t vecs[NVEC];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Presents one op for a single accept edge, then counts busy cycles (bounded).
    task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int cyc);
        bus.i_MDU_valid = 1'b1;
        bus.i_MDU_op    = o;
        bus.i_MDU_rs    = a;
        bus.i_MDU_rt    = b;
        tick();
        bus.i_MDU_valid = 1'b0;
        bus.i_MDU_op    = OP_NOP;
        cyc = 0;
        while (bus.o_MDU_busy && cyc < 100) begin
            cyc++;
            tick();
        end
    endtask

    // Reference model from the arithmetic definition of each op.
    task automatic model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         inout logic [W-1:0] hi, inout logic [W-1:0] lo, output int cyc);
        longint      sa, sb;
        logic [63:0] p;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        cyc = 0;
        case (o)
            OP_MULT:  begin p = 64'(sa * sb); hi = p[63:32]; lo = p[31:0]; cyc = LAT; end
            OP_MULTU: begin p = {32'd0, a} * {32'd0, b}; hi = p[63:32]; lo = p[31:0]; cyc = LAT; end
            OP_DIV, OP_DIVU: begin
                cyc = LAT;
                if (b == 0) begin
                    hi = a;
                    lo = '1;
                end else if (o == OP_DIV) begin
                    lo = W'(sa / sb);
                    hi = W'(sa % sb);
                end else begin
                    lo = a / b;
                    hi = a % b;
                end
            end
            OP_MTHI: hi = a;
            OP_MTLO: lo = a;
            default: ;
        endcase
    endtask

    initial begin
        int          cyc;
        int          n;
        int          bad;
        logic [W-1:0] m_hi, m_lo, a, b;
        logic [2:0]  o;
        int          ecyc;

        n_checks = 0;
        n_pass   = 0;

        vecs[0]  = '{OP_MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, LAT};
        vecs[1]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, LAT};
        vecs[2]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, LAT};
        vecs[3]  = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, LAT};
        vecs[4]  = '{OP_DIVU,  32'd7,        32'd2,        32'd1,        32'd3,        LAT};
        vecs[5]  = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, LAT};
        vecs[6]  = '{OP_DIV,   32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, LAT};
        vecs[7]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, LAT};
        vecs[8]  = '{OP_MTHI,  32'h1234ABCD, 32'd9,        32'h1234ABCD, 32'h80000000, 0};
        vecs[9]  = '{OP_MTLO,  32'h000055AA, 32'd9,        32'h1234ABCD, 32'h000055AA, 0};
        vecs[10] = '{OP_MF,    32'hDEADBEEF, 32'd9,        32'h1234ABCD, 32'h000055AA, 0};
        vecs[11] = '{OP_DIVU,  32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, LAT};
        vecs[12] = '{OP_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, LAT};

        rst             = 1'b1;
        bus.i_MDU_valid = 1'b0;
        bus.i_MDU_op    = OP_NOP;
        bus.i_MDU_rs    = '0;
        bus.i_MDU_rt    = '0;
        tick();
        tick();
        rst = 1'b0;

        chk("reset_hi",    bus.o_MDU_hi, 0);
        chk("reset_lo",    bus.o_MDU_lo, 0);
        chk("reset_busy",  bus.o_MDU_busy, 0);
        chk("reset_state", dbg_state, S_IDLE);
        bus.i_MDU_valid = 1'b1;
        bus.i_MDU_op    = OP_MF;
        #1;
        chk("reset_stall", bus.o_MDU_stall, 0);
        bus.i_MDU_valid = 1'b0;
        bus.i_MDU_op    = OP_NOP;

        for (int i = 0; i < NVEC; i++) begin
            run_op(vecs[i].op, vecs[i].rs, vecs[i].rt, cyc);
            chk($sformatf("vec%0d_cycles", i), cyc, vecs[i].exp_cyc);
            chk($sformatf("vec%0d_hi", i), bus.o_MDU_hi, vecs[i].exp_hi);
            chk($sformatf("vec%0d_lo", i), bus.o_MDU_lo, vecs[i].exp_lo);
        end

        run_op(OP_MTHI, '0, '0, cyc);
        run_op(OP_MTLO, '0, '0, cyc);
        m_hi = '0;
        m_lo = '0;
        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(1, 7));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = '0;
                1: b = '1;
                2: a = 32'h80000000;
                3: begin a = W'($urandom_range(0, 200)); b = W'($urandom_range(1, 20)); end
                default: ;
            endcase
            model(o, a, b, m_hi, m_lo, ecyc);
            run_op(o, a, b, cyc);
            chk($sformatf("rnd%0d_op%0d_cycles", i, o), cyc, ecyc);
            chk($sformatf("rnd%0d_op%0d_hi", i, o), bus.o_MDU_hi, m_hi);
            chk($sformatf("rnd%0d_op%0d_lo", i, o), bus.o_MDU_lo, m_lo);
        end

        // MF held right behind a MULT: stalls for the whole busy window, HI/LO hold old values.
        run_op(OP_MTHI, 32'h0000AAAA, '0, cyc);
        run_op(OP_MTLO, 32'h00005555, '0, cyc);
        bus.i_MDU_valid = 1'b1;
        bus.i_MDU_op    = OP_MULT;
        bus.i_MDU_rs    = 32'd3;
        bus.i_MDU_rt    = 32'd5;
        tick();
        bus.i_MDU_op = OP_MF;
        n   = 0;
        bad = 0;
        while (bus.o_MDU_stall && n < 100) begin
            if (bus.o_MDU_hi !== 32'h0000AAAA || bus.o_MDU_lo !== 32'h00005555) bad++;
            n++;
            tick();
        end
        chk("mf_stall_cycles", n, LAT);
        chk("mf_hold_old",     bad, 0);
        chk("mf_new_hi",       bus.o_MDU_hi, 0);
        chk("mf_new_lo",       bus.o_MDU_lo, 15);
        tick();
        bus.i_MDU_valid = 1'b0;
        bus.i_MDU_op    = OP_NOP;

        // MTHI stalled behind a MULT takes effect only when re-presented in IDLE.
        bus.i_MDU_valid = 1'b1;
        bus.i_MDU_op    = OP_MULT;
        bus.i_MDU_rs    = 32'h00010000;
        bus.i_MDU_rt    = 32'h00030000;
        tick();
        bus.i_MDU_op = OP_MTHI;
        bus.i_MDU_rs = 32'h0000BEEF;
        n   = 0;
        bad = 0;
        while (bus.o_MDU_stall && n < 100) begin
            if (bus.o_MDU_hi !== 32'd0) bad++;
            n++;
            tick();
        end
        chk("mthi_stall_cycles", n, LAT);
        chk("mthi_hi_held",      bad, 0);
        chk("mthi_mul_hi",       bus.o_MDU_hi, 3);
        chk("mthi_mul_lo",       bus.o_MDU_lo, 0);
        tick();
        bus.i_MDU_valid = 1'b0;
        bus.i_MDU_op    = OP_NOP;
        chk("mthi_applied_hi", bus.o_MDU_hi, 32'h0000BEEF);
        chk("mthi_applied_lo", bus.o_MDU_lo, 0);

        // Reset in the middle of a DIV discards the result.
        run_op(OP_MTLO, 32'h77, '0, cyc);
        bus.i_MDU_valid = 1'b1;
        bus.i_MDU_op    = OP_DIV;
        bus.i_MDU_rs    = 32'd100;
        bus.i_MDU_rt    = 32'd7;
        tick();
        bus.i_MDU_valid = 1'b0;
        bus.i_MDU_op    = OP_NOP;
        repeat (9) tick();
        chk("rst_div_busy_before", bus.o_MDU_busy, 1);
        rst             = 1'b1;
        bus.i_MDU_valid = 1'b1;
        bus.i_MDU_op    = OP_MF;
        tick();
        chk("rst_div_busy",  bus.o_MDU_busy, 0);
        chk("rst_div_stall", bus.o_MDU_stall, 0);
        chk("rst_div_hi",    bus.o_MDU_hi, 0);
        chk("rst_div_lo",    bus.o_MDU_lo, 0);
        chk("rst_div_state", dbg_state, S_IDLE);
        rst             = 1'b0;
        bus.i_MDU_valid = 1'b0;
        bus.i_MDU_op    = OP_NOP;
        run_op(OP_MTHI, 32'h1234, '0, cyc);
        chk("post_rst_mthi_hi", bus.o_MDU_hi, 32'h1234);
        chk("post_rst_mthi_lo", bus.o_MDU_lo, 0);
        repeat (40) tick();
        chk("post_rst_quiet_hi", bus.o_MDU_hi, 32'h1234);
        chk("post_rst_quiet_lo", bus.o_MDU_lo, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
